sorted_streamer: RTL and testbench
==================================

SORTED_STREAMER -- requirements
Module: sorted_streamer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bit width of one squared-distance entry.
REQ-002 The block SHALL have parameter n, default 8, where the sorted vector holds N = 2*n entries.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port c, input, 2*n*WIDTH bits, the sorted distance vector from the sorter stage; entry i occupies bits [(i+1)*WIDTH-1 : i*WIDTH], and entry 0 is the smallest.
REQ-006 The block SHALL have port in_valid, input, 1 bit, which asserts that c holds a complete sorted list.
REQ-007 The block SHALL have port in_ready, output, 1 bit, which indicates that the block can capture c.
REQ-008 The block SHALL have port k, input, 5 bits, the number of smallest entries to emit; it is sampled at capture.
REQ-009 The block SHALL have port out_ready, input, 1 bit, the downstream acceptance signal.
REQ-010 The block SHALL have port out_valid, output, 1 bit, which qualifies out_data, out_idx and out_last.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, the current distance entry.
REQ-012 The block SHALL have port out_idx, output, clog2(N) bits, the rank of the current entry (0 = smallest).
REQ-013 The block SHALL have port out_last, output, 1 bit, which marks the final entry of the current list.
REQ-014 The block SHALL have port busy, output, 1 bit, which is high while a captured list is held or streaming.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and STREAM.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 A capture SHALL occur on a clock edge where the FSM is in IDLE and in_valid=1. The capture SHALL register all N entries of c into an internal N x WIDTH buffer, latch the effective count, clear the rank counter to 0, and move the FSM to STREAM.
REQ-018 The effective count SHALL be N when k=0 or k>=N; otherwise it SHALL be k.
REQ-019 In STREAM, in_ready SHALL be 0, and in_valid SHALL be ignored, with no capture and no error.
REQ-020 In STREAM, out_valid SHALL be 1.
REQ-021 In STREAM, out_data SHALL equal buffer[rank] and out_idx SHALL equal rank.
REQ-022 In STREAM, out_last SHALL be 1 exactly when rank = effective count - 1.
REQ-023 The first out_valid SHALL appear one cycle after the capture edge (latency 1).
REQ-024 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1. On a transfer, rank SHALL increment; if out_last=1, the FSM SHALL return to IDLE instead.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable until the transfer.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready.
REQ-027 On the edge that transfers the last entry, the block SHALL NOT capture. in_ready SHALL rise the following cycle, so the minimum gap between lists is 1 idle cycle.
REQ-028 The rank counter SHALL never exceed N-1, and SHALL NOT wrap within a list.
REQ-029 busy SHALL be 1 exactly when the FSM is in STREAM.
REQ-030 Entries SHALL be passed unmodified, with no arithmetic on distances. Entry order SHALL be the rank order given by c, without re-sorting.

Reset
REQ-031 While rst=0, the FSM SHALL be in IDLE.
REQ-032 While rst=0, rank, the effective count and the buffer SHALL be 0.
REQ-033 While rst=0, the outputs SHALL be out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0 and in_ready=1.
REQ-034 Assertion of rst mid-stream SHALL abort the list immediately and asynchronously, with no further out_valid.
REQ-035 After deassertion of rst, the first capture SHALL be possible on the first clock edge with in_valid=1.

Verification
REQ-036 Default parameters, c entries 0..15 = 0x0001..0x0010, k=0, out_ready tied 1, in_valid pulsed once -> 16 consecutive beats out_data 0x0001..0x0010 with out_idx 0..15; out_last only on beat 16; first beat 1 cycle after capture.
REQ-037 k=3, same c -> exactly 3 beats (0x0001, 0x0002, 0x0003), out_last on the third beat, then in_ready=1 on the next cycle.
REQ-038 k=20 -> the count clamps to 16 and exactly 16 beats are emitted.
REQ-039 out_ready toggled 1,0,0,1,0,1,... with k=4 -> each beat held stable across stall cycles, 4 transfers in order, no duplicates or drops.
REQ-040 in_valid held high throughout with a different c presented during STREAM -> the second list is ignored until IDLE, then captured on the first IDLE edge; its beats match the c present at that edge.
REQ-041 rst driven low after the 5th beat of a 16-entry list -> out_valid=0 and busy=0 without waiting for a clock edge; after release, a new capture streams from out_idx=0.

Source files
------------

// File: rtl/sorted_streamer.sv
// Purpose: captures a sorted N-entry distance vector and streams its k smallest entries in rank order.
// Latency: first beat is presented one cycle after the capture edge; one beat per out_ready cycle after that.
// Backpressure: out_ready low holds the current beat stable; in_ready is low while a list is held or streaming.
//
// Ports:
//   clk, rst             single clock, asynchronous active-low reset
//   c, in_valid/in_ready  sorted input vector (entry 0 smallest) and capture handshake
//   k                    number of entries to emit, sampled at capture (0 or >= N means all N)
//   out_valid/out_ready   output handshake qualifying out_data, out_idx, out_last
//   busy                 high while a captured list is streaming
module sorted_streamer #(
  parameter int WIDTH = 16,
  parameter int n     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*n*WIDTH-1:0]      c,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                k,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(2*n)-1:0]    out_idx,
  output logic                      out_last,
  output logic                      busy
);

  localparam int N  = 2 * n;
  localparam int IW = $clog2(N);
  // One extra bit so the effective count can hold N itself.
  localparam int CW = IW + 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    rank_q, rank_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q [N];

  logic             streaming;
  logic             capture;
  logic             xfer;
  logic             at_last;
  logic [CW-1:0]    k_eff;

  assign streaming = (state_q == S_STREAM);
  assign capture   = (state_q == S_IDLE) && in_valid;
  assign xfer      = streaming && out_ready;
  assign at_last   = streaming && ({1'b0, rank_q} == (cnt_q - CW'(1)));

  // k of zero or at least N means "emit the whole list".
  always_comb begin
    k_eff = CW'(N);
    if ((k != 5'd0) && (32'(k) < N)) begin
      k_eff = CW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_STREAM;
          rank_d  = '0;
          cnt_d   = k_eff;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (at_last) begin
            // Return to idle without capturing; rank parks at 0.
            state_d = S_IDLE;
            rank_d  = '0;
          end else begin
            rank_d  = rank_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        rank_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rank_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rank_q  <= rank_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= c[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready  = !streaming;
  assign out_valid = streaming;
  assign busy      = streaming;
  assign out_idx   = rank_q;
  assign out_last  = at_last;
  assign out_data  = streaming ? buf_q[rank_q] : '0;

endmodule

// File: tb/tb_sorted_streamer.sv
// Purpose: randomized scoreboard bench for sorted_streamer at default parameters.
// Latency: checks the first beat one cycle after capture and the idle cycle after each list.
// Backpressure: out_ready is driven tied-high, in a fixed stall pattern, or randomly.
module tb_sorted_streamer;

  localparam int WIDTH = 16;
  localparam int NN    = 8;
  localparam int N     = 2 * NN;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [3:0]       idx;
    logic             last;
  } beat_t;

  logic                 clk;
  logic                 rst;
  logic [N*WIDTH-1:0]   c;
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           k;
  logic                 out_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [3:0]           out_idx;
  logic                 out_last;
  logic                 busy;

  int    checks;
  int    errors;
  int    xfer_cnt;
  int    rdy_mode;
  int    rdy_phase;
  bit    chk_idle;
  beat_t sb [$];
  logic [WIDTH-1:0] ent [N];

  sorted_streamer #(.WIDTH(WIDTH), .n(NN)) dut (
    .clk       (clk),
    .rst       (rst),
    .c         (c),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k         (k),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Mode 0: always ready. Mode 1: repeating 1,0,0,1,0,1. Mode 2: random.
  initial begin
    out_ready = 1'b1;
    rdy_phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = (rdy_phase == 0 || rdy_phase == 3 || rdy_phase == 5);
          rdy_phase = (rdy_phase + 1) % 6;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every presented beat with the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (chk_idle) begin
        check("idle_after_last.in_ready", 32'(in_ready), 32'd1);
        check("idle_after_last.out_valid", 32'(out_valid), 32'd0);
        chk_idle = 1'b0;
      end
      check("busy_eq_valid", 32'(busy), 32'(out_valid));
      check("in_ready_eq_not_valid", 32'(in_ready), 32'(!out_valid));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual idx=%0d data=0x%0h required no beat", out_idx, out_data);
        end else begin
          check("beat", {out_data, out_idx, out_last}, 32'(sb[0]));
          if (out_ready) begin
            if (sb[0].last) chk_idle = 1'b1;
            void'(sb.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  function automatic logic [N*WIDTH-1:0] pack_ent();
    logic [N*WIDTH-1:0] v;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = ent[i];
    return v;
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < N; i++) ent[i] = WIDTH'(i + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) ent[i] = WIDTH'($urandom);
  endtask

  // Waits for idle, presents ent/kk, queues the expected list and checks the
  // first beat one cycle after the capture edge. Leaves in_valid high.
  task automatic capture(input int kk);
    int waited;
    int eff;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: actual in_ready=0 required 1");
      return;
    end
    c        = pack_ent();
    k        = 5'(kk);
    in_valid = 1'b1;
    eff = (kk == 0 || kk >= N) ? N : kk;
    for (int i = 0; i < eff; i++) begin
      beat_t b;
      b.d    = ent[i];
      b.idx  = 4'(i);
      b.last = (i == eff - 1);
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    check("latency.out_valid", 32'(out_valid), 32'd1);
    check("latency.out_idx", 32'(out_idx), 32'd0);
    check("latency.out_data", 32'(out_data), 32'(ent[0]));
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || busy) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check("list_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_list(input int kk, input int mode);
    rdy_mode = mode;
    capture(kk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    xfer_cnt = 0;
    rdy_mode = 0;
    chk_idle = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    k        = '0;
    c        = '0;
    fill_seq();

    repeat (3) @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.out_last", 32'(out_last), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    check("reset.out_idx", 32'(out_idx), 32'd0);
    rst = 1'b1;

    // Full list, tied-ready; k=3; k clamps to 16; stall pattern with k=4.
    fill_seq();
    run_list(0, 0);
    run_list(3, 0);
    run_list(20, 0);
    run_list(4, 1);
    run_list(16, 1);

    // in_valid held high with a new vector presented mid-stream.
    rdy_mode = 2;
    fill_rand();
    capture($urandom_range(4, 20));
    @(negedge clk);
    fill_rand();
    c = pack_ent();
    capture($urandom_range(0, 31));
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();

    // Randomized lists.
    for (int t = 0; t < 12; t++) begin
      fill_rand();
      run_list($urandom_range(0, 31), $urandom_range(0, 2));
    end

    // Asynchronous reset after the fifth beat of a full list.
    begin
      int base;
      int waited;
      fill_seq();
      rdy_mode = 0;
      base = xfer_cnt;
      capture(0);
      @(negedge clk);
      in_valid = 1'b0;
      waited = 0;
      while (xfer_cnt < base + 5 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check("abort.beats_before_reset", 32'(xfer_cnt - base), 32'd5);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("abort.out_valid", 32'(out_valid), 32'd0);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.in_ready", 32'(in_ready), 32'd1);
      check("abort.out_idx", 32'(out_idx), 32'd0);
      check("abort.out_last", 32'(out_last), 32'd0);
      check("abort.out_data", 32'(out_data), 32'd0);
      sb.delete();
      chk_idle = 1'b0;
      repeat (2) @(negedge clk);
      check("abort.held_idle", 32'(out_valid), 32'd0);
      rst = 1'b1;
      fill_rand();
      run_list($urandom_range(5, 16), 2);
    end

    repeat (3) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
